bpu_predictor: RTL

Branch prediction unit for the fetch stage. It holds a table of 2-bit saturating counters (the BHT) indexed by PC and returns a registered taken/not-taken prediction with the next fetch PC. It keeps each in-flight prediction in an in-order queue. When execute resolves a branch through `cmp` `o_branch`, the block checks it against the queued prediction, trains the BHT, and raises a one-cycle mispredict/redirect.

---
 rtl/bpu_predictor_if.sv | 40 ++++
 rtl/bpu_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bpu_predictor_if.sv
// Bundles the fetch-side prediction port and the execute-side resolve port of
// the branch prediction unit.
//   master : drives i_* (fetch/execute), observes o_*
//   slave  : the predictor; observes i_*, drives o_*
// i_pred_*    : branch offered for prediction (valid, pc, decoded target)
// o_pred_*    : ready (combinational) and the registered prediction
// i_resolve_* : actual outcome of the oldest in-flight branch
// o_*         : mispredict/redirect pulse, empty-resolve error, occupancy
interface bpu_predictor_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                i_pred_valid;
    logic [PC_WIDTH-1:0] i_pred_pc;
    logic [PC_WIDTH-1:0] i_pred_target;
    logic                o_pred_ready;
    logic                o_pred_valid;
    logic                o_pred_taken;
    logic [PC_WIDTH-1:0] o_pred_next_pc;
    logic                i_resolve_valid;
    logic                i_resolve_taken;
    logic                o_mispredict;
    logic [PC_WIDTH-1:0] o_redirect_pc;
    logic                o_resolve_err;
    logic [CNT_W-1:0]    o_count;

    modport master (
        output i_pred_valid, i_pred_pc, i_pred_target, i_resolve_valid, i_resolve_taken,
        input  o_pred_ready, o_pred_valid, o_pred_taken, o_pred_next_pc,
        input  o_mispredict, o_redirect_pc, o_resolve_err, o_count
    );

    modport slave (
        input  i_pred_valid, i_pred_pc, i_pred_target, i_resolve_valid, i_resolve_taken,
        output o_pred_ready, o_pred_valid, o_pred_taken, o_pred_next_pc,
        output o_mispredict, o_redirect_pc, o_resolve_err, o_count
    );
endinterface

// File: rtl/bpu_predictor.sv
// Branch prediction unit: a table of 2-bit saturating counters (BHT) indexed
// by pc[2 +: log2(BHT_ENTRIES)] gives a registered taken/not-taken prediction
// and next fetch PC. Each accepted prediction is held in an in-order circular
// queue until execute resolves it; the resolve trains the BHT and, on a
// direction mismatch, raises a one-cycle mispredict with the correct PC and
// flushes every younger in-flight entry.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bpu_predictor_if slave modport (prediction + resolve ports)
module bpu_predictor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    bpu_predictor_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
        logic                pred;
        logic [IDX_W-1:0]    idx;
    } entry_t;

    // State
    logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
    entry_t [QUEUE_DEPTH-1:0]    queue_q, queue_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // Registered outputs
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [PC_WIDTH-1:0] pred_next_pc_q, pred_next_pc_d;
    logic                mispredict_q, mispredict_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                resolve_err_q, resolve_err_d;

    // Combinational helpers
    logic             pred_ready;
    logic             push;
    logic             pop;
    logic             mispred;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_taken;
    entry_t           head;
    logic [1:0]       head_ctr;
    logic [1:0]       train_ctr;

    always_comb begin
        pred_ready   = !rst && (count_q != FULL_COUNT);
        lookup_idx   = bus.i_pred_pc[2 +: IDX_W];
        // Lookup uses the pre-update table, so a same-cycle train is not seen.
        lookup_taken = bht_q[lookup_idx][1];
        head         = queue_q[rd_ptr_q];
        head_ctr     = bht_q[head.idx];
        // Ready is not relaxed by a same-cycle pop.
        push         = bus.i_pred_valid && pred_ready;
        pop          = bus.i_resolve_valid && (count_q != '0);
        mispred      = pop && (bus.i_resolve_taken != head.pred);
    end

    // Saturating counter training for the popped entry
    always_comb begin
        train_ctr = head_ctr;
        if (bus.i_resolve_taken) begin
            if (head_ctr != 2'b11) begin
                train_ctr = head_ctr + 2'b01;
            end
        end else begin
            if (head_ctr != 2'b00) begin
                train_ctr = head_ctr - 2'b01;
            end
        end
    end

    always_comb begin
        bht_d          = bht_q;
        queue_d        = queue_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        pred_valid_d   = 1'b0;
        pred_taken_d   = 1'b0;
        pred_next_pc_d = '0;
        mispredict_d   = 1'b0;
        redirect_pc_d  = '0;
        resolve_err_d  = bus.i_resolve_valid && (count_q == '0);

        if (pop) begin
            bht_d[head.idx] = train_ctr;
        end

        if (mispred) begin
            // Drop the head and everything younger; the same-cycle push is lost too.
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            wr_ptr_d      = rd_ptr_q + PTR_W'(1);
            count_d       = '0;
            mispredict_d  = 1'b1;
            redirect_pc_d = bus.i_resolve_taken ? head.target : head.pc + PC_WIDTH'(4);
        end else begin
            if (push) begin
                queue_d[wr_ptr_q] = '{
                    pc:     bus.i_pred_pc,
                    target: bus.i_pred_target,
                    pred:   lookup_taken,
                    idx:    lookup_idx
                };
                wr_ptr_d       = wr_ptr_q + PTR_W'(1);
                pred_valid_d   = 1'b1;
                pred_taken_d   = lookup_taken;
                pred_next_pc_d = lookup_taken ? bus.i_pred_target
                                              : bus.i_pred_pc + PC_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht_q          <= {BHT_ENTRIES{2'b01}};
            queue_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_next_pc_q <= '0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= '0;
            resolve_err_q  <= 1'b0;
        end else begin
            bht_q          <= bht_d;
            queue_q        <= queue_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            pred_valid_q   <= pred_valid_d;
            pred_taken_q   <= pred_taken_d;
            pred_next_pc_q <= pred_next_pc_d;
            mispredict_q   <= mispredict_d;
            redirect_pc_q  <= redirect_pc_d;
            resolve_err_q  <= resolve_err_d;
        end
    end

    assign bus.o_pred_ready   = pred_ready;
    assign bus.o_pred_valid   = pred_valid_q;
    assign bus.o_pred_taken   = pred_taken_q;
    assign bus.o_pred_next_pc = pred_next_pc_q;
    assign bus.o_mispredict   = mispredict_q;
    assign bus.o_redirect_pc  = redirect_pc_q;
    assign bus.o_resolve_err  = resolve_err_q;
    assign bus.o_count        = count_q;
endmodule
